apb_master_nslave: RTL and testbench

- Parametrised APB master bridge. Converts the single-beat user transfer request (i_ptransfer, i_pwrite, i_pwaddr/i_praddr, i_pwdata) into APB3 SETUP/ACCESS cycles toward NUM_SLAVES decoded slaves.
- Successor of the fixed two-slave master. Adds slave-count generalisation, pready wait states, pslverr return, decode error, a wait-state timeout and back-to-back transfers.
- Sits between the test/user driver and the slave array.

---
 rtl/apb_master_nslave.sv | 242 ++++++++++++++++++++++++
 tb/tb_apb_master_nslave.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_nslave.sv
// ---------------------------------------------------------------------------
// apb_master_nslave
// APB3 master bridge. Turns a single-beat user request into SETUP/ACCESS
// cycles toward NUM_SLAVES address-decoded slaves. It supports pready wait
// states, pslverr return, a decode error for unmapped slave indices, an
// optional wait-state timeout and back-to-back transfers.
//
// Ports
//   pclk, preset              clock, synchronous active-high reset
//   i_ptransfer               request valid, taken on an edge where o_ready=1
//   i_pwrite                  1 = write, 0 = read
//   i_pwaddr / i_praddr       write / read address
//   i_pwdata, i_pstrb         write data and byte strobes
//   o_ready                   request can be accepted this cycle
//   o_done                    one-cycle completion pulse
//   o_prdata                  read data, held until the next o_done
//   o_pslverr, o_timeout      completion status, held until the next o_done
//   psel, penable, paddr,
//   pwrite, pwdata, pstrb     APB request side
//   prdata, pready, pslverr   APB response side, one lane per slave
// ---------------------------------------------------------------------------
module apb_master_nslave #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SBW        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     i_ptransfer,
  input  logic                     i_pwrite,
  input  logic [AW-1:0]            i_pwaddr,
  input  logic [AW-1:0]            i_praddr,
  input  logic [DW-1:0]            i_pwdata,
  input  logic [DW/8-1:0]          i_pstrb,
  output logic                     o_ready,
  output logic                     o_done,
  output logic [DW-1:0]            o_prdata,
  output logic                     o_pslverr,
  output logic                     o_timeout,
  output logic [NUM_SLAVES-1:0]    psel,
  output logic                     penable,
  output logic [AW-1:0]            paddr,
  output logic                     pwrite,
  output logic [DW-1:0]            pwdata,
  output logic [DW/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DW-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]    pready,
  input  logic [NUM_SLAVES-1:0]    pslverr
);

  // Slave lanes padded to a power of two so any SBW-bit index is in range.
  localparam int NSP = 1 << SBW;
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);
  localparam logic [SBW:0]   NS_VAL = (SBW + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SBW-1:0]          idx_q, idx_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [AW-1:0]           paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DW-1:0]           pwdata_q, pwdata_d;
  logic [DW/8-1:0]         pstrb_q, pstrb_d;
  logic                    done_q, done_d;
  logic [DW-1:0]           prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;
  logic                    timeout_q, timeout_d;
  logic [CW-1:0]           waitCnt_q, waitCnt_d;

  logic [NSP-1:0]          preadyExt;
  logic [NSP-1:0]          pslverrExt;
  logic [NSP*DW-1:0]       prdataExt;
  logic [AW-1:0]           reqAddr;
  logic [SBW-1:0]          reqIdx;
  logic                    reqValid;
  logic [NUM_SLAVES-1:0]   reqSel;
  logic [CW-1:0]           waitCntInc;
  logic                    captureReq;

  // Request decode: address mux, slave index and one-hot select of the
  // incoming request, plus zero-padded copies of the slave response lanes.
  always_comb begin
    preadyExt                   = '0;
    preadyExt[NUM_SLAVES-1:0]   = pready;
    pslverrExt                  = '0;
    pslverrExt[NUM_SLAVES-1:0]  = pslverr;
    prdataExt                   = '0;
    prdataExt[NUM_SLAVES*DW-1:0] = prdata;
    reqAddr  = i_pwrite ? i_pwaddr : i_praddr;
    reqIdx   = reqAddr[AW-1 -: SBW];
    reqValid = ({1'b0, reqIdx} < NS_VAL);
    reqSel   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      reqSel[k] = (reqIdx == SBW'(k));
    end
    waitCntInc = waitCnt_q + CW'(1);
  end

  // A new request can be taken when idle, or on the completion edge of the
  // current ACCESS, which is what gives the 2-cycle back-to-back rate.
  assign o_ready = (state_q == IDLE) || ((state_q == ACCESS) && preadyExt[idx_q]);

  // Next-state and register updates. Everything holds by default; o_done is
  // a pulse and defaults low. A capture at the end overrides the bus fields
  // both from IDLE and from a completing ACCESS.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    done_d     = 1'b0;
    prdata_d   = prdata_q;
    pslverr_d  = pslverr_q;
    timeout_d  = timeout_q;
    waitCnt_d  = waitCnt_q;
    captureReq = 1'b0;

    unique case (state_q)
      IDLE: begin
        captureReq = i_ptransfer;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (preadyExt[idx_q]) begin
          done_d    = 1'b1;
          pslverr_d = pslverrExt[idx_q];
          timeout_d = 1'b0;
          if (!pwrite_q) begin
            prdata_d = prdataExt[idx_q*DW +: DW];
          end
          if (i_ptransfer) begin
            captureReq = 1'b1;
          end else begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
          end
        end else begin
          waitCnt_d = waitCntInc;
          // Abort on the TIMEOUT-th consecutive wait cycle.
          if ((TIMEOUT != 0) && (waitCntInc == TO_VAL)) begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
            done_d    = 1'b1;
            pslverr_d = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      DERR: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        pslverr_d = 1'b1;
        timeout_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (captureReq) begin
      paddr_d   = reqAddr;
      pwrite_d  = i_pwrite;
      pwdata_d  = i_pwdata;
      pstrb_d   = i_pwrite ? i_pstrb : '0;
      idx_d     = reqIdx;
      penable_d = 1'b0;
      waitCnt_d = '0;
      if (reqValid) begin
        state_d = SETUP;
        psel_d  = reqSel;
      end else begin
        state_d = DERR;
        psel_d  = '0;
      end
    end
  end

  // State and datapath registers with synchronous reset; a reset in the
  // middle of a transfer simply drops it without a completion pulse.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      done_q    <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      timeout_q <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      done_q    <= done_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      timeout_q <= timeout_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign o_done    = done_q;
  assign o_prdata  = prdata_q;
  assign o_pslverr = pslverr_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// ---------------------------------------------------------------------------
// tb_apb_master_nslave
// Self-checking bench for apb_master_nslave with three slaves, so slave
// index 3 is an unmapped (decode error) region. A driver issues directed and
// random requests and pushes the expected completion into a queue, computed
// from a simple memory-per-address reference model. A slave responder plays
// the slave array and checks the bus fields; a monitor pops the queue on
// every o_done and compares status, data and latency.
// ---------------------------------------------------------------------------
module tb_apb_master_nslave;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 15;

  logic               pclk;
  logic               preset;
  logic               i_ptransfer;
  logic               i_pwrite;
  logic [AW-1:0]      i_pwaddr;
  logic [AW-1:0]      i_praddr;
  logic [DW-1:0]      i_pwdata;
  logic [DW/8-1:0]    i_pstrb;
  logic               o_ready;
  logic               o_done;
  logic [DW-1:0]      o_prdata;
  logic               o_pslverr;
  logic               o_timeout;
  logic [NS-1:0]      psel;
  logic               penable;
  logic [AW-1:0]      paddr;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic [DW/8-1:0]    pstrb;
  logic [NS*DW-1:0]   prdata;
  logic [NS-1:0]      pready;
  logic [NS-1:0]      pslverr;

  apb_master_nslave #(
    .AW(AW), .DW(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .i_ptransfer(i_ptransfer), .i_pwrite(i_pwrite),
    .i_pwaddr(i_pwaddr), .i_praddr(i_praddr),
    .i_pwdata(i_pwdata), .i_pstrb(i_pstrb),
    .o_ready(o_ready), .o_done(o_done), .o_prdata(o_prdata),
    .o_pslverr(o_pslverr), .o_timeout(o_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic            wr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    int              waits;
    logic            err;
    int              slv;
  } cfg_t;

  typedef struct {
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          timeout;
    int            latency;
    int            acceptCycle;
    logic          idleAtDone;
  } exp_t;

  cfg_t          cfgQ[$];
  exp_t          expQ[$];
  logic [DW-1:0] refMem   [0:255];
  logic [DW-1:0] slaveMem [0:255];
  logic [DW-1:0] lastPrdata;
  int            cycle;
  int            checks;
  int            errors;

  cfg_t          cur;
  bit            active;
  int            accCnt;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cycle <= cycle + 1;

  // Global watchdog so a stuck design can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old,
                                               input logic [DW-1:0] nw,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    end
    return r;
  endfunction

  // Reference model: what the user should see for one accepted request.
  task automatic modelIssue(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                            input int waits, input logic err);
    exp_t e;
    cfg_t c;
    int   slv;
    slv = addr / 64;
    e.acceptCycle = cycle;
    e.timeout     = 1'b0;
    e.idleAtDone  = 1'b0;
    if (slv >= NS) begin
      e.prdata = lastPrdata; e.pslverr = 1'b1; e.latency = 2; e.idleAtDone = 1'b1;
    end else begin
      c.addr = addr; c.wr = wr; c.data = data; c.strb = wr ? strb : '0;
      c.waits = waits; c.err = err; c.slv = slv;
      cfgQ.push_back(c);
      if (waits >= TO) begin
        e.prdata = lastPrdata; e.pslverr = 1'b1; e.timeout = 1'b1;
        e.latency = 2 + TO; e.idleAtDone = 1'b1;
      end else begin
        e.latency = 3 + waits;
        e.pslverr = err;
        if (wr) begin
          if (!err) refMem[addr] = mergeBytes(refMem[addr], data, strb);
        end else begin
          lastPrdata = refMem[addr];
        end
        e.prdata = lastPrdata;
      end
    end
    expQ.push_back(e);
  endtask

  // Called at a falling edge; holds the request until the DUT takes it and
  // returns at the falling edge after the accepting edge, i_ptransfer still 1.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                               input int waits, input logic err);
    bit accepted;
    int guard;
    accepted    = 0;
    guard       = 0;
    i_ptransfer = 1'b1;
    i_pwrite    = wr;
    i_pwaddr    = wr ? addr : AW'($urandom);
    i_praddr    = wr ? AW'($urandom) : addr;
    i_pwdata    = wr ? data : $urandom;
    i_pstrb     = wr ? strb : (DW/8)'($urandom);
    while (!accepted && guard < 100) begin
      #4;
      if (o_ready) begin
        accepted = 1;
        modelIssue(wr, addr, data, strb, waits, err);
      end
      @(negedge pclk);
      guard++;
    end
    if (!accepted) checkOutput("acceptBound", 64'd0, 64'd1);
  endtask

  task automatic idleCycles(input int n);
    i_ptransfer = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_psel"},    64'(psel),      64'd0);
    checkOutput({tag, "_penable"}, 64'(penable),   64'd0);
    checkOutput({tag, "_paddr"},   64'(paddr),     64'd0);
    checkOutput({tag, "_pwrite"},  64'(pwrite),    64'd0);
    checkOutput({tag, "_pwdata"},  64'(pwdata),    64'd0);
    checkOutput({tag, "_pstrb"},   64'(pstrb),     64'd0);
    checkOutput({tag, "_done"},    64'(o_done),    64'd0);
    checkOutput({tag, "_prdata"},  64'(o_prdata),  64'd0);
    checkOutput({tag, "_pslverr"}, 64'(o_pslverr), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    checkOutput({tag, "_ready"},   64'(o_ready),   64'd1);
  endtask

  // Slave array model: checks each SETUP/ACCESS against the request it
  // expects and answers with the configured wait states, error and data.
  // Unselected lanes and out-of-ACCESS pready carry random noise.
  initial begin : responder
    active  = 0;
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    forever begin
      @(negedge pclk);
      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      prdata  = {$urandom, $urandom, $urandom};
      if (preset) begin
        active = 0;
      end else if (psel != '0 && !penable) begin
        active = 0;
        if (cfgQ.size() == 0) checkOutput("unexpectedPsel", 64'(psel), 64'd0);
        else checkOutput("setupPsel", 64'(psel), 64'(1 << cfgQ[0].slv));
      end else if (psel != '0 && penable) begin
        if (!active) begin
          if (cfgQ.size() == 0) begin
            checkOutput("unexpectedAccess", 64'(psel), 64'd0);
          end else begin
            cur    = cfgQ.pop_front();
            active = 1;
            accCnt = 0;
          end
        end
        if (active) begin
          checkOutput("accessPsel",   64'(psel),   64'(1 << cur.slv));
          checkOutput("accessPaddr",  64'(paddr),  64'(cur.addr));
          checkOutput("accessPwrite", 64'(pwrite), 64'(cur.wr));
          checkOutput("accessPstrb",  64'(pstrb),  64'(cur.strb));
          if (cur.wr) checkOutput("accessPwdata", 64'(pwdata), 64'(cur.data));
          pready[cur.slv]  = (accCnt >= cur.waits);
          pslverr[cur.slv] = cur.err;
          prdata[cur.slv*DW +: DW] = slaveMem[cur.addr];
          if (pready[cur.slv] && cur.wr && !cur.err)
            slaveMem[cur.addr] = mergeBytes(slaveMem[cur.addr], pwdata, pstrb);
          accCnt++;
        end
      end else begin
        active = 0;
      end
    end
  end

  // Completion monitor: every o_done must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      #1;
      if (o_done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 64'(o_done), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("donePrdata",  64'(o_prdata),  64'(e.prdata));
          checkOutput("donePslverr", 64'(o_pslverr), 64'(e.pslverr));
          checkOutput("doneTimeout", 64'(o_timeout), 64'(e.timeout));
          checkOutput("doneLatency", 64'(cycle - e.acceptCycle), 64'(e.latency));
          if (e.idleAtDone) checkOutput("doneIdlePsel", 64'(psel), 64'd0);
        end
      end
    end
  end

  initial begin : driver
    logic [1:0]      rSlv;
    logic [AW-1:0]   rAddr;
    logic            rWr;
    logic [DW-1:0]   rData;
    logic [DW/8-1:0] rStrb;
    int              rWaits;
    int              pick;
    logic            rErr;
    int              drain;

    checks      = 0;
    errors      = 0;
    cycle       = 0;
    lastPrdata  = '0;
    preset      = 1'b1;
    i_ptransfer = 1'b0;
    i_pwrite    = 1'b0;
    i_pwaddr    = '0;
    i_praddr    = '0;
    i_pwdata    = '0;
    i_pstrb     = '0;
    for (int a = 0; a < 256; a++) begin
      refMem[a]   = 32'h1000_0000 + 32'(a) * 32'h0001_0101;
      slaveMem[a] = 32'h1000_0000 + 32'(a) * 32'h0001_0101;
    end

    repeat (3) @(negedge pclk);
    #1;
    checkResetValues("reset");
    preset = 1'b0;
    @(negedge pclk);

    $display("[TB] directed: write then read slave 1");
    applyStimulus(1'b1, 8'h40, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 8'h40, 32'h0, 4'h0, 0, 1'b0);
    idleCycles(4);
    checkOutput("planReadData", 64'(o_prdata), 64'hDEADBEEF);

    $display("[TB] directed: wait states and timeout boundary");
    applyStimulus(1'b1, 8'h80, 32'h1234_5678, 4'h5, 3, 1'b0);
    idleCycles(8);
    applyStimulus(1'b0, 8'h80, 32'h0, 4'h0, 14, 1'b0);
    idleCycles(20);
    applyStimulus(1'b0, 8'h41, 32'h0, 4'h0, 15, 1'b0);
    idleCycles(20);
    applyStimulus(1'b1, 8'h02, 32'hCAFE_F00D, 4'hF, 1000, 1'b0);
    idleCycles(20);

    $display("[TB] directed: decode error");
    applyStimulus(1'b0, 8'hC0, 32'h0, 4'h0, 0, 1'b0);
    idleCycles(4);

    $display("[TB] directed: back-to-back slave 0 then slave 2");
    applyStimulus(1'b1, 8'h03, 32'hA5A5_0001, 4'hF, 0, 1'b0);
    applyStimulus(1'b0, 8'h80, 32'h0, 4'h0, 0, 1'b0);
    idleCycles(5);

    $display("[TB] directed: slave error");
    applyStimulus(1'b0, 8'h01, 32'h0, 4'h0, 0, 1'b1);
    idleCycles(4);

    $display("[TB] directed: reset during ACCESS");
    applyStimulus(1'b0, 8'h42, 32'h0, 4'h0, 6, 1'b0);
    i_ptransfer = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;
    void'(expQ.pop_back());
    lastPrdata = '0;
    @(negedge pclk);
    #1;
    checkResetValues("midReset");
    preset = 1'b0;
    idleCycles(8);

    $display("[TB] random phase");
    for (int t = 0; t < 60; t++) begin
      pick  = $urandom_range(0, 9);
      rSlv  = (pick == 9) ? 2'd3 : 2'(pick % 3);
      rAddr = {rSlv, 3'b000, 3'($urandom_range(0, 7))};
      rWr   = 1'($urandom_range(0, 1));
      rData = $urandom;
      rStrb = 4'($urandom_range(0, 15));
      pick  = $urandom_range(0, 19);
      if (pick < 12)       rWaits = 0;
      else if (pick < 17)  rWaits = $urandom_range(1, 3);
      else if (pick == 17) rWaits = TO - 1;
      else if (pick == 18) rWaits = TO;
      else                 rWaits = TO + 5;
      rErr = ($urandom_range(0, 7) == 0);
      applyStimulus(rWr, rAddr, rData, rStrb, rWaits, rErr);
      if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(0, 3));
    end
    i_ptransfer = 1'b0;

    drain = 0;
    while (expQ.size() != 0 && drain < 100) begin
      @(negedge pclk);
      drain++;
    end
    repeat (3) @(negedge pclk);
    checkOutput("drainExpQ", 64'(expQ.size()), 64'd0);
    checkOutput("drainCfgQ", 64'(cfgQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
